// File: rtl/syscall_string_writer.sv
`default_nettype none
// =============================================================================
// Module  : syscall_string_writer
// Brief   : Read-string syscall engine; stores console bytes as a NUL-terminated
//           string through a byte-enabled write port into data memory.
// Rev     : 1.0
// =============================================================================
module syscall_string_writer #(
  parameter int MAX_LEN_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [31:0]          a0_i,
  input  logic [MAX_LEN_W-1:0] a1_i,
  input  logic                 in_valid_i,
  input  logic [7:0]           in_data_i,
  output logic                 in_ready_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_a_o,
  output logic [3:0]           mem_be_o,
  output logic [31:0]          mem_write_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [MAX_LEN_W-1:0] count_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_TERM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          ptr_q, ptr_d;
  logic [MAX_LEN_W-1:0] limit_q, limit_d;
  logic [MAX_LEN_W-1:0] count_q, count_d, count_inc;
  logic [7:0]           byte_q, byte_d;
  logic                 writing_d;

  logic                 in_ready_q, mem_write_q, busy_q, done_q;
  logic [31:0]          mem_a_q, mem_write_data_q;
  logic [3:0]           mem_be_q;

  assign count_inc = count_q + MAX_LEN_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    limit_d = limit_q;
    count_d = count_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ptr_d   = a0_i;
          limit_d = a1_i;
          count_d = '0;
          if (a1_i == '0)                 state_d = S_DONE;
          else if (a1_i == MAX_LEN_W'(1)) state_d = S_TERM;
          else                            state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (in_valid_i) begin
          // An in-stream NUL ends the string without being stored itself.
          if (in_data_i == 8'h00) begin
            state_d = S_TERM;
          end else begin
            byte_d  = in_data_i;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        ptr_d   = ptr_q + 32'd1;
        count_d = count_inc;
        if (byte_q == 8'h0A || count_inc == limit_q - MAX_LEN_W'(1)) state_d = S_TERM;
        else                                                          state_d = S_RECV;
      end
      S_TERM:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign writing_d = (state_d == S_WRITE) || (state_d == S_TERM);

  // Outputs are registered from the next-state values so they line up with the
  // state they describe and never depend combinationally on the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      ptr_q            <= '0;
      limit_q          <= '0;
      count_q          <= '0;
      byte_q           <= '0;
      in_ready_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_a_q          <= '0;
      mem_be_q         <= '0;
      mem_write_data_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      limit_q          <= limit_d;
      count_q          <= count_d;
      byte_q           <= byte_d;
      in_ready_q       <= (state_d == S_RECV);
      mem_write_q      <= writing_d;
      mem_a_q          <= writing_d ? ptr_d : 32'd0;
      mem_be_q         <= writing_d ? (4'b0001 << ptr_d[1:0]) : 4'b0000;
      mem_write_data_q <= (state_d == S_WRITE) ? {4{byte_d}} : 32'd0;
      busy_q           <= (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_TERM);
      done_q           <= (state_d == S_DONE);
    end
  end

  assign in_ready_o       = in_ready_q;
  assign mem_write_o      = mem_write_q;
  assign mem_a_o          = mem_a_q;
  assign mem_be_o         = mem_be_q;
  assign mem_write_data_o = mem_write_data_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign count_o          = count_q;

endmodule
`default_nettype wire

// File: tb/tb_syscall_string_writer.sv
`default_nettype none
// =============================================================================
// Module  : tb_syscall_string_writer
// Brief   : Directed table-driven bench for syscall_string_writer.
// Rev     : 1.0
// =============================================================================
module tb_syscall_string_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a0 = '0;
  logic [31:0] a1 = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_write, busy, done;
  logic [31:0] mem_a, mem_write_data, count;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  syscall_string_writer #(.MAX_LEN_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .a0_i             (a0),
    .a1_i             (a1),
    .in_valid_i       (in_valid),
    .in_data_i        (in_data),
    .in_ready_o       (in_ready),
    .mem_write_o      (mem_write),
    .mem_a_o          (mem_a),
    .mem_be_o         (mem_be),
    .mem_write_data_o (mem_write_data),
    .busy_o           (busy),
    .done_o           (done),
    .count_o          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " in_ready"},  {31'd0, in_ready},  32'd0);
    check({tag, " mem_write"}, {31'd0, mem_write}, 32'd0);
    check({tag, " mem_a"},     mem_a,              32'd0);
    check({tag, " mem_be"},    {28'd0, mem_be},    32'd0);
    check({tag, " wdata"},     mem_write_data,     32'd0);
    check({tag, " busy"},      {31'd0, busy},      32'd0);
    check({tag, " done"},      {31'd0, done},      32'd0);
    check({tag, " count"},     count,              32'd0);
  endtask

  // Byte i of the offered stream lives in bytes[8*i +: 8].
  typedef struct packed {
    logic [31:0] a0;
    logic [31:0] a1;
    int          nbytes;
    logic [63:0] bytes;
    int          gap_max;
    bit          restart;
    int          exp_consumed;
    int          exp_writes;
    int          exp_count;
    int          exp_done_cyc;   // -1: timing depends on random gaps
  } vec_t;

  task automatic run_vec(input vec_t v, input int vi);
    int          cyc = 0;
    int          idx = 0;
    int          nw = 0;
    int          gap = 0;
    bit          xfer;
    bit          got_done = 0;
    logic [31:0] exp_a;
    logic [63:0] bb;
    string       tag;
    tag = $sformatf("v%0d", vi);
    bb  = v.bytes;

    @(negedge clk);
    a0 = v.a0; a1 = v.a1; start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = (idx < v.nbytes);
    in_data  = bb[8*idx +: 8];
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_write) begin
        exp_a = v.a0 + 32'(nw);
        check($sformatf("%s w%0d addr", tag, nw), mem_a, exp_a);
        check($sformatf("%s w%0d be", tag, nw), {28'd0, mem_be}, {28'd0, 4'b0001 << exp_a[1:0]});
        check($sformatf("%s w%0d data", tag, nw), mem_write_data,
              (nw < v.exp_count) ? {4{bb[8*nw +: 8]}} : 32'd0);
        check($sformatf("%s w%0d in_ready", tag, nw), {31'd0, in_ready}, 32'd0);
        nw++;
      end
      if (done) begin
        got_done = 1;
        if (v.exp_done_cyc >= 0) check({tag, " done cycle"}, 32'(cyc), 32'(v.exp_done_cyc));
        check({tag, " count"}, count, 32'(v.exp_count));
        check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
      end
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      start = v.restart && (cyc == 3);
      if (v.restart && cyc == 3) a0 = 32'hDEAD_0000;
      if (xfer) begin
        idx++;
        gap = (v.gap_max > 0) ? int'($urandom_range(0, v.gap_max)) : 0;
      end else if (gap > 0) begin
        gap--;
      end
      in_valid = (idx < v.nbytes) && (gap == 0);
      in_data  = bb[8*idx +: 8];
    end
    start = 1'b0;
    if (!got_done) check({tag, " done timeout"}, 32'd0, 32'd1);
    check({tag, " writes"}, 32'(nw), 32'(v.exp_writes));
    check({tag, " consumed"}, 32'(idx), 32'(v.exp_consumed));
    @(negedge clk);
    check({tag, " idle in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, " count held"}, count, 32'(v.exp_count));
    in_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    //           a0            a1     nb  bytes              gap rs cons wr cnt done
    vecs[0] = '{32'h0040_0100, 32'd10, 3, 64'h0000_0000_000A_6968, 0, 1'b0, 3, 4, 3, 8};
    vecs[1] = '{32'h0000_2000, 32'd3,  4, 64'h0000_0000_6463_6261, 0, 1'b0, 2, 3, 2, 6};
    vecs[2] = '{32'h0000_3000, 32'd0,  1, 64'h0000_0000_0000_007A, 0, 1'b0, 0, 0, 0, 1};
    vecs[3] = '{32'h0000_4005, 32'd1,  1, 64'h0000_0000_0000_0071, 0, 1'b0, 0, 1, 0, 2};
    vecs[4] = '{32'h0000_5003, 32'd16, 5, 64'h0000_007A_7A00_7978, 5, 1'b1, 3, 3, 2, -1};
    vecs[5] = '{32'h0000_1002, 32'd2,  2, 64'h0000_0000_0000_6261, 0, 1'b0, 1, 2, 1, 4};

    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Address wrap at the top of memory, then reset mid-string.
    @(negedge clk);
    a0 = 32'hFFFF_FFFF; a1 = 32'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h70;
    @(negedge clk);
    check("wrap c1 in_ready", {31'd0, in_ready}, 32'd1);
    check("wrap c1 busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    in_data = 8'h71;
    @(negedge clk);
    check("wrap w0 mem_write", {31'd0, mem_write}, 32'd1);
    check("wrap w0 addr", mem_a, 32'hFFFF_FFFF);
    check("wrap w0 be", {28'd0, mem_be}, 32'h8);
    check("wrap w0 data", mem_write_data, 32'h7070_7070);
    @(negedge clk);
    check("wrap c3 in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_data = 8'h72;
    @(negedge clk);
    check("wrap w1 mem_write", {31'd0, mem_write}, 32'd1);
    check("wrap w1 addr", mem_a, 32'h0000_0000);
    check("wrap w1 be", {28'd0, mem_be}, 32'h1);
    check("wrap w1 data", mem_write_data, 32'h7171_7171);
    @(negedge clk);
    check("wrap c5 in_ready", {31'd0, in_ready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("held rst mem_write c%0d", k), {31'd0, mem_write}, 32'd0);
      check($sformatf("held rst busy c%0d", k), {31'd0, busy}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst in_ready", {31'd0, in_ready}, 32'd0);
    check("post rst mem_write", {31'd0, mem_write}, 32'd0);
    in_valid = 1'b0;

    // Engine still usable after the reset.
    run_vec(vecs[5], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
